// File: rtl/serial_to_parallel_receiver.sv
// rtl/serial_to_parallel_receiver.sv - MSB-first framed serial-to-parallel receiver
// Frame length is framesize+1 bits, latched at frame start; the word is right-aligned.
module serial_to_parallel_receiver #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic [WIDTH-1:0] framesize,
   input  logic             receive,
   input  logic             serial,
   output logic [WIDTH-1:0] parallel,
   output logic             complete,
   output logic             busy,
   output logic             abort
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] fs;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   count;
   logic             last_bit;
   logic             fs_zero;

   // shreg is held at zero outside a frame, so short frames come out right-aligned.
   assign shifted  = {shreg[WIDTH-2:0], serial};
   assign last_bit = (count == {1'b0, fs});
   assign fs_zero  = (framesize == '0);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= ST_IDLE;
      end else if (Enable) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (receive) begin
               state_nxt = fs_zero ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!receive) begin
               state_nxt = ST_IDLE;
            end else if (last_bit) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!receive) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy     = 1'b0;
      complete = 1'b0;
      case (state)
         ST_SHIFT: busy     = 1'b1;
         ST_DONE:  complete = 1'b1;
         default: begin
            busy     = 1'b0;
            complete = 1'b0;
         end
      endcase
   end

   // Datapath; abort is a registered single-cycle pulse and is cleared on any disabled edge.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         shreg    <= '0;
         fs       <= '0;
         count    <= '0;
         parallel <= '0;
         abort    <= 1'b0;
      end else if (!Enable) begin
         abort <= 1'b0;
      end else begin
         abort <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (receive) begin
                  fs    <= framesize;
                  shreg <= shifted;
                  count <= CNT_ONE;
                  if (fs_zero) begin
                     parallel <= shifted;
                  end
               end
            end
            ST_SHIFT: begin
               if (receive) begin
                  shreg <= shifted;
                  count <= count + CNT_ONE;
                  if (last_bit) begin
                     parallel <= shifted;
                  end
               end else begin
                  shreg <= '0;
                  count <= '0;
                  abort <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!receive) begin
                  shreg <= '0;
                  count <= '0;
               end
            end
            default: begin
               shreg <= '0;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// tb/tb_serial_to_parallel_receiver.sv - randomized self-checking bench for the serial receiver
module tb_serial_to_parallel_receiver;

   localparam int WIDTH = 8;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             Enable;
   logic [WIDTH-1:0] framesize;
   logic             receive;
   logic             serial;
   logic [WIDTH-1:0] parallel;
   logic             complete;
   logic             busy;
   logic             abort;

   int               n_compared   = 0;
   int               n_mismatched = 0;
   logic [WIDTH-1:0] last_word;
   bit               bitq[$];

   serial_to_parallel_receiver #(.WIDTH(WIDTH)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Enable    (Enable),
      .framesize (framesize),
      .receive   (receive),
      .serial    (serial),
      .parallel  (parallel),
      .complete  (complete),
      .busy      (busy),
      .abort     (abort)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Reference: the word is the last WIDTH bits of the frame read as a binary number.
   function automatic logic [WIDTH-1:0] model_word();
      int unsigned acc;
      acc = 0;
      foreach (bitq[i]) acc = (acc * 2 + bitq[i]) % (1 << WIDTH);
      return acc[WIDTH-1:0];
   endfunction

   task automatic load_pattern(input logic [31:0] pat, input int n);
      bitq.delete();
      for (int i = n - 1; i >= 0; i--) bitq.push_back(pat[i]);
   endtask

   task automatic load_random(input int n);
      bitq.delete();
      for (int i = 0; i < n; i++) bitq.push_back(1'($urandom_range(1)));
   endtask

   task automatic drive_bits(input int n);
      for (int k = 0; k < n; k++) begin
         serial = bitq[k];
         tick();
      end
   endtask

   task automatic run_frame(input int fs, input int stall_at, input int stall_len,
                            input int stall_pct, input int hold_extra);
      logic [WIDTH-1:0] exp;
      exp       = model_word();
      framesize = fs[WIDTH-1:0];
      receive   = 1'b1;
      Enable    = 1'b1;
      for (int k = 0; k <= fs; k++) begin
         int ns;
         ns = (k == stall_at) ? stall_len : 0;
         if (stall_pct > 0 && $urandom_range(99) < stall_pct) ns += $urandom_range(1, 3);
         for (int s = 0; s < ns; s++) begin
            Enable = 1'b0;
            serial = 1'($urandom_range(1));
            if (k > 0) framesize = WIDTH'($urandom);
            tick();
            n_compared++;
            if (busy !== (k > 0) || complete !== 1'b0 || parallel !== last_word || abort !== 1'b0) begin
               n_mismatched++;
               $display("FAIL stall fs=%0d bit=%0d: busy=%b complete=%b abort=%b parallel=%h, expected busy=%b complete=0 abort=0 parallel=%h",
                        fs, k, busy, complete, abort, parallel, (k > 0), last_word);
            end
         end
         Enable = 1'b1;
         serial = bitq[k];
         if (k > 0) framesize = WIDTH'($urandom);
         tick();
         if (k < fs) begin
            n_compared++;
            if (busy !== 1'b1 || complete !== 1'b0 || parallel !== last_word) begin
               n_mismatched++;
               $display("FAIL shift fs=%0d bit=%0d: busy=%b complete=%b parallel=%h, expected busy=1 complete=0 parallel=%h",
                        fs, k, busy, complete, parallel, last_word);
            end
         end
      end
      n_compared++;
      if (complete !== 1'b1 || busy !== 1'b0 || parallel !== exp) begin
         n_mismatched++;
         $display("FAIL done fs=%0d: complete=%b busy=%b parallel=%h, expected complete=1 busy=0 parallel=%h",
                  fs, complete, busy, parallel, exp);
      end
      last_word = exp;
      for (int h = 0; h < hold_extra; h++) begin
         serial = 1'($urandom_range(1));
         tick();
         n_compared++;
         if (complete !== 1'b1 || parallel !== exp) begin
            n_mismatched++;
            $display("FAIL hold fs=%0d: complete=%b parallel=%h, expected complete=1 parallel=%h",
                     fs, complete, parallel, exp);
         end
      end
   endtask

   task automatic end_frame();
      receive = 1'b0;
      serial  = 1'bx;
      Enable  = 1'b1;
      tick();
      n_compared++;
      if (complete !== 1'b0 || busy !== 1'b0 || abort !== 1'b0 || parallel !== last_word) begin
         n_mismatched++;
         $display("FAIL end_frame: complete=%b busy=%b abort=%b parallel=%h, expected 0 0 0 parallel=%h",
                  complete, busy, abort, parallel, last_word);
      end
   endtask

   task automatic abort_frame(input int fs, input int nbits);
      framesize = fs[WIDTH-1:0];
      receive   = 1'b1;
      Enable    = 1'b1;
      drive_bits(nbits);
      receive = 1'b0;
      serial  = 1'bx;
      tick();
      n_compared++;
      if (abort !== 1'b1 || complete !== 1'b0 || busy !== 1'b0 || parallel !== last_word) begin
         n_mismatched++;
         $display("FAIL abort fs=%0d after %0d bits: abort=%b complete=%b busy=%b parallel=%h, expected abort=1 complete=0 busy=0 parallel=%h",
                  fs, nbits, abort, complete, busy, parallel, last_word);
      end
      tick();
      n_compared++;
      if (abort !== 1'b0) begin
         n_mismatched++;
         $display("FAIL abort_pulse_width: abort=%b, expected 0", abort);
      end
   endtask

   task automatic test_reset();
      Reset     = 1'b1;
      Enable    = 1'b0;
      receive   = 1'b0;
      serial    = 1'b0;
      framesize = '0;
      tick();
      tick();
      n_compared++;
      if (parallel !== '0 || complete !== 1'b0 || busy !== 1'b0 || abort !== 1'b0) begin
         n_mismatched++;
         $display("FAIL reset: parallel=%h complete=%b busy=%b abort=%b, expected all zero",
                  parallel, complete, busy, abort);
      end
      Reset = 1'b0;
      tick();
      last_word = '0;
   endtask

   task automatic test_directed();
      load_pattern(32'hA5, 8);
      run_frame(7, -1, 0, 0, 2);
      end_frame();
      load_pattern(32'hB, 4);
      run_frame(3, -1, 0, 0, 0);
      end_frame();
   endtask

   task automatic test_enable_stall();
      load_pattern(32'hA5, 8);
      run_frame(7, 3, 2, 0, 0);
      end_frame();
   endtask

   task automatic test_abort();
      load_pattern(32'hA5, 8);
      run_frame(7, -1, 0, 0, 0);
      end_frame();
      load_random(8);
      abort_frame(7, 3);
      load_pattern(32'h3, 2);
      run_frame(1, -1, 0, 0, 0);
      end_frame();
   endtask

   task automatic test_fs_edges();
      load_pattern(32'h1, 1);
      run_frame(0, -1, 0, 0, 1);
      end_frame();
      load_pattern(32'h30F, 10);
      run_frame(9, -1, 0, 0, 0);
      end_frame();
      load_random(256);
      run_frame(255, -1, 0, 0, 0);
      end_frame();
   endtask

   task automatic test_reset_mid_frame();
      load_pattern(32'hA5, 8);
      run_frame(7, -1, 0, 0, 0);
      end_frame();
      load_pattern(32'h5A, 8);
      framesize = 8'd7;
      receive   = 1'b1;
      drive_bits(5);
      Reset = 1'b1;
      #1;
      n_compared++;
      if (parallel !== '0 || busy !== 1'b0 || complete !== 1'b0 || abort !== 1'b0) begin
         n_mismatched++;
         $display("FAIL reset_mid_frame: parallel=%h busy=%b complete=%b abort=%b, expected all zero",
                  parallel, busy, complete, abort);
      end
      receive = 1'b0;
      tick();
      Reset = 1'b0;
      tick();
      last_word = '0;
      load_pattern(32'h3C, 8);
      run_frame(7, -1, 0, 0, 0);
      end_frame();
   endtask

   task automatic test_back_to_back_random();
      for (int it = 0; it < 30; it++) begin
         int fs;
         fs = $urandom_range(0, 20);
         load_random(fs + 1);
         if (fs > 0 && $urandom_range(3) == 0) begin
            abort_frame(fs, $urandom_range(1, fs));
         end else begin
            run_frame(fs, -1, 0, 25, $urandom_range(0, 2));
            end_frame();
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_enable_stall();
      test_abort();
      test_fs_edges();
      test_reset_mid_frame();
      test_back_to_back_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
